// File: rtl/csr_file.sv
// Machine-mode CSR file and trap sequencer beside execute; 32- or 64-bit XLEN from one source.
// Latency: reads/illegal flag combinational (pre-write value); writes visible next cycle; redirect registered, 1 cycle.
// Backpressure: none; every access, trap and MRET is accepted in the cycle it is presented.
module csr_file #(
    parameter int              XLEN        = 64,   // 32 or 64 only
    parameter int              HART_ID     = 0,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSTATUSH = 12'h310;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam bit              HAS_MSTATUSH = (XLEN == 32);
    localparam logic [1:0]      MXL          = (XLEN == 32) ? 2'd1 : 2'd2;
    localparam logic [XLEN-1:0] MISA_VAL     = {MXL, {(XLEN-11){1'b0}}, 9'h100};

    // The three machine interrupt sources share one layout for mie, mip and arbitration.
    typedef struct packed {
        logic meie;
        logic mtie;
        logic msie;
    } irq_vec_t;

    // Architectural state
    logic            mstatus_mie;
    logic            mstatus_mpie;
    irq_vec_t        mie_q;
    irq_vec_t        mip_q;
    logic [XLEN-3:0] mtvec_base;
    logic [1:0]      mtvec_mode;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            redirect_vld_q;
    logic [XLEN-1:0] redirect_pc_q;

    // Read-side views and access decode
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mie_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            addr_impl;
    logic            addr_ro;
    logic            addr_hartid;
    logic            wants_write;
    logic            csr_we;

    // Trap target and interrupt arbitration
    logic [XLEN-1:0] tvec_base_addr;
    logic [XLEN:0]   vec_sum;
    logic [XLEN-1:0] trap_target;
    irq_vec_t        pend_vec;
    logic [3:0]      irq_code;
    logic            unused_bits;

    // Assemble the bit-sparse CSRs from their stored fields
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mstatus_mpie;
        mstatus_val[3]     = mstatus_mie;
        mie_val            = '0;
        mie_val[11]        = mie_q.meie;
        mie_val[7]         = mie_q.mtie;
        mie_val[3]         = mie_q.msie;
        mip_val            = '0;
        mip_val[11]        = mip_q.meie;
        mip_val[7]         = mip_q.mtie;
        mip_val[3]         = mip_q.msie;
    end

    // Address decode: old value, whether implemented, whether writes are dropped
    always_comb begin
        old_val     = '0;
        addr_impl   = 1'b1;
        addr_ro     = 1'b0;
        addr_hartid = 1'b0;
        case (csr_addr_i)
            A_MHARTID: begin
                old_val     = XLEN'(HART_ID);
                addr_ro     = 1'b1;
                addr_hartid = 1'b1;
            end
            A_MISA: begin
                old_val = MISA_VAL;
                addr_ro = 1'b1;
            end
            A_MSTATUS:  old_val = mstatus_val;
            A_MSTATUSH: begin
                if (HAS_MSTATUSH) begin
                    addr_ro = 1'b1;
                end else begin
                    addr_impl = 1'b0;
                end
            end
            A_MIE:      old_val = mie_val;
            A_MIP: begin
                old_val = mip_val;
                addr_ro = 1'b1;
            end
            A_MTVEC:    old_val = {mtvec_base, mtvec_mode};
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MTVAL:    old_val = mtval_q;
            default:    addr_impl = 1'b0;
        endcase
    end

    // RS/RC with a zero operand are pure reads, so they are legal even on mhartid
    assign wants_write = (csr_op_i == OP_RW) || (csr_wdata_i != '0);

    assign csr_illegal_o = csr_valid_i &&
                           (!addr_impl || (csr_op_i == OP_NONE) || (addr_hartid && wants_write));
    assign csr_rdata_o   = old_val;

    // Read-modify-write value for the three access flavours
    always_comb begin
        new_val = csr_wdata_i;
        if (csr_op_i == OP_RS) begin
            new_val = old_val | csr_wdata_i;
        end else if (csr_op_i != OP_RW) begin
            new_val = old_val & ~csr_wdata_i;
        end
    end

    // Trap and MRET pre-empt the CSR write completely in the same cycle
    assign csr_we = csr_valid_i && !csr_illegal_o && wants_write && !addr_ro &&
                    !trap_valid_i && !mret_i;

    // Vectored mode only applies to interrupts; exceptions always land on BASE
    assign tvec_base_addr = {mtvec_base, 2'b00};
    assign vec_sum        = {1'b0, tvec_base_addr} + {trap_cause_i[XLEN-2:0], 2'b00};
    assign trap_target    = ((mtvec_mode == 2'd1) && trap_cause_i[XLEN-1]) ?
                            vec_sum[XLEN-1:0] : tvec_base_addr;
    assign unused_bits    = ^{vec_sum[XLEN], trap_pc_i[1:0]};

    // Fixed-priority interrupt pick: external, then software, then timer
    always_comb begin
        pend_vec = mip_q & mie_q;
        irq_code = 4'd0;
        if (pend_vec.meie) begin
            irq_code = 4'd11;
        end else if (pend_vec.msie) begin
            irq_code = 4'd3;
        end else if (pend_vec.mtie) begin
            irq_code = 4'd7;
        end
    end

    assign irq_pending_o = mstatus_mie && (|pend_vec);
    assign irq_cause_o   = irq_pending_o ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : '0;

    // Interrupt lines are sampled through a single flop into mip
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mip_q <= '0;
        end else begin
            mip_q <= '{meie: irq_ext_i, mtie: irq_timer_i, msie: irq_sw_i};
        end
    end

    // mstatus interrupt-enable stack: trap pushes, MRET pops, CSR write lowest
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_valid_i) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we && (csr_addr_i == A_MSTATUS)) begin
            mstatus_mie  <= new_val[3];
            mstatus_mpie <= new_val[7];
        end
    end

    // Trap recording and ordinary CSR writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q      <= '0;
            mtvec_base <= RESET_MTVEC[XLEN-1:2];
            mtvec_mode <= RESET_MTVEC[1:0];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid_i) begin
            mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_tval_i;
        end else if (csr_we) begin
            case (csr_addr_i)
                A_MIE:      mie_q <= '{meie: new_val[11], mtie: new_val[7], msie: new_val[3]};
                A_MTVEC: begin
                    mtvec_base <= new_val[XLEN-1:2];
                    // Reserved modes leave the current mode in place
                    if (!new_val[1]) begin
                        mtvec_mode <= new_val[1:0];
                    end
                end
                A_MSCRATCH: mscratch_q <= new_val;
                A_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_q   <= new_val;
                A_MTVAL:    mtval_q    <= new_val;
                default: ;
            endcase
        end
    end

    // One-cycle redirect pulse per trap/MRET; target is zero when idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            redirect_vld_q <= trap_valid_i || mret_i;
            if (trap_valid_i) begin
                redirect_pc_q <= trap_target;
            end else if (mret_i) begin
                redirect_pc_q <= mepc_q;
            end else begin
                redirect_pc_q <= '0;
            end
        end
    end

    assign redirect_valid_o = redirect_vld_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: a 64-bit and a 32-bit instance driven in lockstep.
// Inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Every expected value below is hand-computed from the register definitions.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [63:0] wdata64, cause64, pc64, tval64;
    logic [31:0] wdata32, cause32, pc32, tval32;
    logic        trap_valid, mret, irq_sw, irq_timer, irq_ext;

    logic [63:0] rdata64, icause64, rpc64;
    logic [31:0] rdata32, icause32, rpc32;
    logic        ill64, ill32, pend64, pend32, rv64, rv32;

    logic [63:0] r64;
    logic [31:0] r32;
    logic        i64, i32;

    int checks = 0;
    int errors = 0;

    assign wdata32 = wdata64[31:0];
    assign pc32    = pc64[31:0];
    assign tval32  = tval64[31:0];
    assign cause32 = {cause64[63], cause64[30:0]};

    always #5 clk = ~clk;

    csr_file #(.XLEN(64), .HART_ID(5), .RESET_MTVEC(64'h200)) dut64 (
        .clk_i(clk), .rst_i(rst),
        .csr_valid_i(csr_valid), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
        .csr_wdata_i(wdata64), .csr_rdata_o(rdata64), .csr_illegal_o(ill64),
        .trap_valid_i(trap_valid), .trap_cause_i(cause64), .trap_pc_i(pc64),
        .trap_tval_i(tval64), .mret_i(mret),
        .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
        .irq_pending_o(pend64), .irq_cause_o(icause64),
        .redirect_valid_o(rv64), .redirect_pc_o(rpc64)
    );

    csr_file #(.XLEN(32), .HART_ID(5), .RESET_MTVEC(32'h200)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .csr_valid_i(csr_valid), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
        .csr_wdata_i(wdata32), .csr_rdata_o(rdata32), .csr_illegal_o(ill32),
        .trap_valid_i(trap_valid), .trap_cause_i(cause32), .trap_pc_i(pc32),
        .trap_tval_i(tval32), .mret_i(mret),
        .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
        .irq_pending_o(pend32), .irq_cause_o(icause32),
        .redirect_valid_o(rv32), .redirect_pc_o(rpc32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CSR access, entered at posedge+1; captures combinational outputs mid-cycle
    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        wdata64   = wd;
        #2;
        r64 = rdata64;
        r32 = rdata32;
        i64 = ill64;
        i32 = ill32;
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
        csr_op    = 2'b00;
        wdata64   = '0;
    endtask

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; wdata64 = '0;
        trap_valid = 1'b0; cause64 = '0; pc64 = '0; tval64 = '0; mret = 1'b0;
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_rv64", rv64, 0);
        check("rst_rv32", rv32, 0);
        check("rst_pend64", pend64, 0);
        access(2'b10, 12'h305, 0);
        check("rst_mtvec64", r64, 64'h200);
        check("rst_mtvec32", r32, 64'h200);
        access(2'b10, 12'h300, 0);
        check("rst_mstatus64", r64, 64'h1800);
        check("rst_mstatus32", r32, 64'h1800);
        access(2'b10, 12'h301, 0);
        check("misa64", r64, 64'h8000000000000100);
        check("misa32", r32, 64'h40000100);

        // RW/RS/RC on mscratch; old value is returned
        access(2'b01, 12'h340, 64'hDEAD);
        access(2'b10, 12'h340, 64'h0F00);
        check("rs_old64", r64, 64'hDEAD);
        access(2'b10, 12'h340, 0);
        check("rs_new64", r64, 64'hDFAD);
        check("rs_new32", r32, 64'hDFAD);
        access(2'b11, 12'h340, 64'h000D);
        access(2'b10, 12'h340, 0);
        check("rc_new64", r64, 64'hDFA0);
        access(2'b11, 12'h341, 0);
        check("rc0_legal64", i64, 0);
        check("rc0_legal32", i32, 0);

        // mtvec reserved mode keeps previous mode
        access(2'b01, 12'h305, 64'h2001);
        access(2'b01, 12'h305, 64'h1003);
        check("mtvec_old", r64, 64'h2001);
        access(2'b10, 12'h305, 0);
        check("mtvec_mode64", r64, 64'h1001);
        check("mtvec_mode32", r32, 64'h1001);

        // Illegal accesses
        access(2'b01, 12'h311, 0);
        check("unimpl_ill", i64, 1);
        check("unimpl_rd0", r64, 0);
        access(2'b10, 12'h340, 0);
        check("unimpl_nochg", r64, 64'hDFA0);
        access(2'b01, 12'hF14, 0);
        check("hartid_wr_ill", i64, 1);
        access(2'b10, 12'hF14, 0);
        check("hartid_rd_ill", i64, 0);
        check("hartid_rd", r64, 5);
        access(2'b00, 12'h340, 0);
        check("op00_ill", i32, 1);
        access(2'b10, 12'h310, 0);
        check("mstatush_ill64", i64, 1);
        check("mstatush_ill32", i32, 0);
        check("mstatush_rd32", r32, 0);

        // Interrupt setup: MIE, vectored mtvec 0x100, MTIE
        access(2'b01, 12'h300, 64'h8);
        access(2'b01, 12'h305, 64'h101);
        access(2'b01, 12'h304, 64'h80);
        irq_timer = 1'b1;
        #2;
        check("irq_not_yet", pend64, 0);
        @(posedge clk);
        #1;
        check("irq_pend64", pend64, 1);
        check("irq_pend32", pend32, 1);
        check("irq_cause64", icause64, 64'h8000000000000007);
        check("irq_cause32", icause32, 64'h80000007);
        access(2'b10, 12'h344, 0);
        check("mip_rd", r64, 64'h80);

        // Trap with a simultaneous (dropped) mscratch write
        trap_valid = 1'b1;
        cause64    = 64'h8000000000000007;
        pc64       = 64'h80000042;
        tval64     = 64'h1234;
        access(2'b01, 12'h340, 64'h5555);
        trap_valid = 1'b0;
        check("trap_rv64", rv64, 1);
        check("trap_pc64", rpc64, 64'h11C);
        check("trap_rv32", rv32, 1);
        check("trap_pc32", rpc32, 64'h11C);
        check("trap_mie_off", pend64, 0);

        // MRET on the very next cycle uses the new mepc
        mret = 1'b1;
        access(2'b10, 12'h341, 0);
        mret = 1'b0;
        check("mepc64", r64, 64'h80000040);
        check("mepc32", r32, 64'h80000040);
        check("mret_rv64", rv64, 1);
        check("mret_pc64", rpc64, 64'h80000040);
        check("mret_pc32", rpc32, 64'h80000040);
        access(2'b10, 12'h300, 0);
        check("mret_mstatus64", r64, 64'h1888);
        check("mret_mstatus32", r32, 64'h1888);
        check("pulse_end", rv64, 0);
        check("mret_pend", pend64, 1);
        access(2'b10, 12'h340, 0);
        check("trap_drop_wr", r64, 64'hDFA0);
        access(2'b10, 12'h342, 0);
        check("mcause64", r64, 64'h8000000000000007);
        check("mcause32", r32, 64'h80000007);
        access(2'b10, 12'h343, 0);
        check("mtval", r64, 64'h1234);

        // Exception ignores vectored mode
        irq_timer  = 1'b0;
        trap_valid = 1'b1;
        cause64    = 64'h2;
        pc64       = 64'h400;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        check("exc_pc64", rpc64, 64'h100);
        check("exc_pc32", rpc32, 64'h100);

        // Reset mid-pulse kills the pending redirect
        trap_valid = 1'b1;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        rst        = 1'b1;
        check("pre_rst_rv", rv64, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_rv64", rv64, 0);
        check("mid_rst_rv32", rv32, 0);
        access(2'b10, 12'h305, 0);
        check("mid_rst_mtvec", r64, 64'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR register file and trap sequencer for the core; it supports 32- or 64-bit XLEN from one source. It sits beside the execute stage. It services CSRRW/CSRRS/CSRRC accesses, records trap state on exceptions and interrupts, restores state on MRET, and presents a registered PC redirect to fetch. It also reports the highest-priority enabled pending interrupt to the trap logic.

## Interface
- XLEN, 64, datapath width; only 32 and 64 are legal.
- HART_ID, 0, value returned by mhartid.
- RESET_MTVEC, 0, reset value of mtvec; bits [1:0] are the mode field.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- csr_valid_i  in  1  CSR access this cycle.
- csr_op_i  in  2  access type: 01 = RW, 10 = RS, 11 = RC; 00 = no access.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  XLEN  source operand for the access.
- csr_rdata_o  out  XLEN  old value of the addressed CSR; combinational.
- csr_illegal_o  out  1  access is illegal; combinational.
- trap_valid_i  in  1  take a trap this cycle.
- trap_cause_i  in  XLEN  mcause value; bit XLEN-1 set means interrupt.
- trap_pc_i  in  XLEN  PC to save in mepc.
- trap_tval_i  in  XLEN  value to save in mtval.
- mret_i  in  1  execute MRET this cycle.
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  level-sensitive machine interrupt lines.
- irq_pending_o  out  1  an enabled interrupt is pending and global MIE = 1.
- irq_cause_o  out  XLEN  mcause value of the winning interrupt; 0 when none is pending.
- redirect_valid_o  out  1  one-cycle pulse: fetch must jump.
- redirect_pc_o  out  XLEN  jump target; valid only while redirect_valid_o is high.

## Operation
- Implemented registers, with address and content:
  - mhartid (F14): read-only, returns HART_ID.
  - misa (301): read-only. MXL is 1 for XLEN=32 and 2 for XLEN=64, in bits [XLEN-1:XLEN-2]. Bit 8 (I) is set. Writes are silently ignored.
  - mstatus (300): only MIE (bit 3) and MPIE (bit 7) are writable. MPP (bits 12:11) always reads 2'b11. All other bits read 0.
  - mstatush (310): exists only when XLEN=32 and reads 0. When XLEN=64, any access to 310 is illegal.
  - mie (304): only MSIE (3), MTIE (7) and MEIE (11) are writable; all other bits read 0.
  - mip (344): read-only. Bits 3, 7 and 11 hold the registered irq_sw_i, irq_timer_i and irq_ext_i. Writes are ignored and are not illegal.
  - mtvec (305): BASE is bits [XLEN-1:2]; MODE is bits [1:0], 0 = direct, 1 = vectored. A write with MODE 2 or 3 updates BASE but keeps the previous MODE.
  - mscratch (340), mcause (342), mtval (343): full width, fully writable.
  - mepc (341): full width, but bits [1:0] are forced to 0.
- Write value by access type: RW writes wdata; RS writes old | wdata; RC writes old & ~wdata.
  - RS or RC with wdata == 0 performs no write. This also applies to read-only CSRs, so such an access is legal there.
- csr_illegal_o is asserted when csr_valid_i = 1 and any of the following holds:
  - the address is unimplemented; csr_rdata_o then reads 0;
  - csr_op_i == 00;
  - a write is attempted to mhartid.
  - An illegal access changes no state.
- Write priority within one cycle: rst_i > trap_valid_i > mret_i > CSR write. Lower-priority actions in the same cycle are dropped entirely.
- Trap entry:
  - mepc <= trap_pc_i with bits [1:0] cleared; mcause <= trap_cause_i; mtval <= trap_tval_i.
  - MPIE <= MIE, then MIE <= 0.
- Trap redirect target:
  - mtvec BASE<<2 when MODE = direct, or when the trap is an exception.
  - (BASE<<2) + 4·trap_cause_i[XLEN-2:0] for an interrupt with MODE = vectored.
- MRET: MIE <= MPIE; MPIE <= 1; redirect target = mepc.
- Interrupt arbitration:
  - irq_pending_o = MIE & |(mip & mie).
  - Fixed priority: MEI (cause 11) > MSI (3) > MTI (7).
  - irq_cause_o = {1'b1, code}, zero-extended to XLEN.

## Timing
- Reset values:
  - mstatus MIE = MPIE = 0; mie = 0; mip = 0; mtvec = RESET_MTVEC.
  - mscratch, mepc, mcause and mtval = 0.
  - redirect_valid_o = 0; redirect_pc_o = 0; irq_pending_o = 0.
- csr_rdata_o and csr_illegal_o are combinational, with zero latency. They show the pre-write value.
- CSR writes become visible on the cycle after the access.
- redirect_valid_o and redirect_pc_o are registered. They assert exactly one cycle after trap_valid_i or mret_i, for exactly one cycle.
  - Back-to-back triggers produce back-to-back pulses, each carrying its own target.
- mip samples the interrupt lines through one flop. irq_pending_o therefore rises 1 cycle after the line rises, provided mie and MIE already enable it.
- An MRET issued the cycle after a trap uses the mepc written by that trap.
- Reset asserted mid-operation clears a pending redirect pulse the same edge.

## Test plan
- Reset -> mtvec == RESET_MTVEC, mstatus == 0x1800, redirect_valid_o == 0; read misa (XLEN=64) -> 0x8000000000000100.
- CSRRW mscratch 0xDEAD, then CSRRS with 0x0F00 -> second access returns 0xDEAD; next read returns 0xDFAD. CSRRC mepc with 0 -> no write, not illegal.
- Write mtvec 0x1003 (MODE=3) after mtvec = 0x2001 -> reads 0x1001. Write 0x311 = 0 -> illegal, state unchanged. Write F14 via RW -> illegal.
- MIE=1, mtvec = 0x100 vectored, mie.MTIE=1; raise irq_timer_i -> irq_pending_o one cycle later with irq_cause_o = 0x8000000000000007. Trap with that cause, pc 0x8000_0042 -> next cycle redirect_pc_o = 0x11C, mepc = 0x8000_0040, MIE=0, MPIE=1.
- MRET following that trap -> redirect_pc_o = 0x8000_0040 one cycle later, MIE=1, MPIE=1. Assert trap and CSR write to mscratch in the same cycle -> mscratch unchanged.
- Rerun scenarios 1-4 with XLEN=32 -> misa = 0x40000100, mstatush reads 0, interrupt cause = 0x80000007.
